// File: rtl/ureg_pkg.sv
// rtl/ureg_pkg.sv - shared mode encodings and helpers for universal_register
package ureg_pkg;

  localparam int MODE_W = 3;

  typedef enum logic [MODE_W-1:0] {
    MODE_HOLD = 3'b000,
    MODE_LOAD = 3'b001,
    MODE_SHL  = 3'b010,
    MODE_SHR  = 3'b011,
    MODE_ROTL = 3'b100,
    MODE_ROTR = 3'b101,
    MODE_INC  = 3'b110,
    MODE_DEC  = 3'b111
  } mode_e;

  function automatic logic is_shift(input mode_e m);
    return (m == MODE_SHL) || (m == MODE_SHR) || (m == MODE_ROTL) || (m == MODE_ROTR);
  endfunction

  function automatic logic is_arith(input mode_e m);
    return (m == MODE_INC) || (m == MODE_DEC);
  endfunction

endpackage

// File: rtl/ureg_bit_cell.sv
// rtl/ureg_bit_cell.sv - one register bit: next-value mux plus flip-flop
module ureg_bit_cell
  import ureg_pkg::*;
#(
  parameter logic RST_BIT = 1'b0
) (
  input  logic  i_clk,
  input  logic  i_rst,
  input  logic  i_set,
  input  logic  i_en,
  input  mode_e i_mode,
  input  logic  i_d,
  input  logic  i_lo,
  input  logic  i_hi,
  input  logic  i_arith,
  output logic  o_q
);

  logic r_q;
  logic w_next;

  // i_lo feeds left moves (from the lower bit), i_hi feeds right moves
  always_comb begin
    w_next = r_q;
    if (i_en) begin
      case (i_mode)
        MODE_LOAD:           w_next = i_d;
        MODE_SHL, MODE_ROTL: w_next = i_lo;
        MODE_SHR, MODE_ROTR: w_next = i_hi;
        MODE_INC, MODE_DEC:  w_next = i_arith;
        default:             w_next = r_q;
      endcase
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst)      r_q <= RST_BIT;
    else if (i_set) r_q <= 1'b1;
    else            r_q <= w_next;
  end

  assign o_q = r_q;

endmodule

// File: rtl/universal_register.sv
// rtl/universal_register.sv - load/shift/rotate/count register with SO, CO and Z flags
module universal_register
  import ureg_pkg::*;
#(
  parameter int               WIDTH     = 8,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             CLK,
  input  logic             R,
  input  logic             S,
  input  logic [2:0]       MODE,
  input  logic             EN,
  input  logic [WIDTH-1:0] D,
  input  logic             SI,
  output logic [WIDTH-1:0] Q,
  output logic             SO,
  output logic             CO,
  output logic             Z
);

  mode_e            w_mode;
  logic [WIDTH-1:0] w_q;
  logic [WIDTH-1:0] w_lo;
  logic [WIDTH-1:0] w_hi;
  logic [WIDTH-1:0] w_arith;
  logic             w_so_next;
  logic             w_co_next;
  logic             r_so;
  logic             r_co;

  assign w_mode = mode_e'(MODE);

  // Rotates recirculate the outgoing end bit; plain shifts take SI instead
  assign w_lo    = {w_q[WIDTH-2:0], (w_mode == MODE_ROTL) ? w_q[WIDTH-1] : SI};
  assign w_hi    = {(w_mode == MODE_ROTR) ? w_q[0] : SI, w_q[WIDTH-1:1]};
  assign w_arith = (w_mode == MODE_INC) ? w_q + WIDTH'(1) : w_q - WIDTH'(1);

  assign w_so_next = ((w_mode == MODE_SHL) || (w_mode == MODE_ROTL)) ? w_q[WIDTH-1] : w_q[0];
  assign w_co_next = (w_mode == MODE_INC) ? (&w_q) : ~(|w_q);

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    ureg_bit_cell #(
      .RST_BIT (RESET_VAL[i])
    ) u_cell (
      .i_clk   (CLK),
      .i_rst   (R),
      .i_set   (S),
      .i_en    (EN),
      .i_mode  (w_mode),
      .i_d     (D[i]),
      .i_lo    (w_lo[i]),
      .i_hi    (w_hi[i]),
      .i_arith (w_arith[i]),
      .o_q     (w_q[i])
    );
  end

  always_ff @(posedge CLK) begin
    if (R || S) begin
      r_so <= 1'b0;
      r_co <= 1'b0;
    end else if (EN) begin
      if (is_shift(w_mode)) r_so <= w_so_next;
      if (is_arith(w_mode)) r_co <= w_co_next;
    end
  end

  assign Q  = w_q;
  assign SO = r_so;
  assign CO = r_co;
  assign Z  = ~(|w_q);

endmodule

// File: tb/tb_universal_register.sv
// tb/tb_universal_register.sv - directed vectors plus randomized model comparison
module tb_universal_register;
  import ureg_pkg::*;

  logic       CLK = 1'b0;
  always #5 CLK = ~CLK;

  logic       r8, s8, en8, si8;
  logic [2:0] mode8;
  logic [7:0] d8, q8;
  logic       so8, co8, z8;

  logic       r4, s4, en4, si4;
  logic [2:0] mode4;
  logic [3:0] d4, q4;
  logic       so4, co4, z4;

  universal_register #(.WIDTH(8), .RESET_VAL(8'h00)) dut8 (
    .CLK(CLK), .R(r8), .S(s8), .MODE(mode8), .EN(en8), .D(d8), .SI(si8),
    .Q(q8), .SO(so8), .CO(co8), .Z(z8)
  );

  universal_register #(.WIDTH(4), .RESET_VAL(4'h9)) dut4 (
    .CLK(CLK), .R(r4), .S(s4), .MODE(mode4), .EN(en4), .D(d4), .SI(si4),
    .Q(q4), .SO(so4), .CO(co4), .Z(z4)
  );

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic       r, s, en;
    logic [2:0] mode;
    logic [7:0] d;
    logic       si;
    logic [7:0] q;
    logic       so, co;
    string      name;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input string name, input logic r, input logic s, input logic en,
                              input logic [2:0] mode, input logic [7:0] d, input logic si,
                              input logic [7:0] q, input logic so, input logic co);
    vec_t v;
    v.name = name; v.r = r; v.s = s; v.en = en; v.mode = mode; v.d = d; v.si = si;
    v.q = q; v.so = so; v.co = co;
    return v;
  endfunction

  // Reference behaviour computed with plain integer arithmetic on a w-bit value
  task automatic model(input int w, input int rv, input bit r, input bit s, input bit en,
                       input int mode, input int d, input bit si,
                       inout int q, inout int so, inout int co);
    int m;
    m = 1 << w;
    if (r) begin
      q = rv; so = 0; co = 0;
    end else if (s) begin
      q = m - 1; so = 0; co = 0;
    end else if (en) begin
      case (mode)
        1: q = d % m;
        2: begin so = (q >> (w - 1)) & 1; q = (q * 2 + si) % m; end
        3: begin so = q & 1; q = q / 2 + si * (m / 2); end
        4: begin so = (q >> (w - 1)) & 1; q = (q * 2 + so) % m; end
        5: begin so = q & 1; q = q / 2 + so * (m / 2); end
        6: begin co = (q == m - 1) ? 1 : 0; q = (q + 1) % m; end
        7: begin co = (q == 0) ? 1 : 0; q = (q + m - 1) % m; end
        default: ;
      endcase
    end
  endtask

  task automatic drive8(input logic r, input logic s, input logic en, input logic [2:0] mode,
                        input logic [7:0] d, input logic si);
    r8 = r; s8 = s; en8 = en; mode8 = mode; d8 = d; si8 = si;
  endtask

  task automatic drive4(input logic r, input logic s, input logic en, input logic [2:0] mode,
                        input logic [3:0] d, input logic si);
    r4 = r; s4 = s; en4 = en; mode4 = mode; d4 = d; si4 = si;
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  initial begin
    int q8m, so8m, co8m, q4m, so4m, co4m;
    drive8(1'b0, 1'b0, 1'b0, 3'(MODE_HOLD), 8'h00, 1'b0);
    drive4(1'b0, 1'b0, 1'b0, 3'(MODE_HOLD), 4'h0, 1'b0);

    vecs.push_back(mk("reset",      1, 0, 0, 3'(MODE_HOLD), 8'h00, 0, 8'h00, 0, 0));
    vecs.push_back(mk("set",        0, 1, 1, 3'(MODE_INC),  8'h00, 0, 8'hFF, 0, 0));
    vecs.push_back(mk("load_a5",    0, 0, 1, 3'(MODE_LOAD), 8'hA5, 0, 8'hA5, 0, 0));
    vecs.push_back(mk("shl_si1",    0, 0, 1, 3'(MODE_SHL),  8'h00, 1, 8'h4B, 1, 0));
    vecs.push_back(mk("shr_si0",    0, 0, 1, 3'(MODE_SHR),  8'h00, 0, 8'h25, 1, 0));
    vecs.push_back(mk("load_81",    0, 0, 1, 3'(MODE_LOAD), 8'h81, 1, 8'h81, 1, 0));
    vecs.push_back(mk("rotl",       0, 0, 1, 3'(MODE_ROTL), 8'h00, 0, 8'h03, 1, 0));
    vecs.push_back(mk("rotr",       0, 0, 1, 3'(MODE_ROTR), 8'h00, 0, 8'h81, 1, 0));
    vecs.push_back(mk("load_fe",    0, 0, 1, 3'(MODE_LOAD), 8'hFE, 0, 8'hFE, 1, 0));
    vecs.push_back(mk("inc_ff",     0, 0, 1, 3'(MODE_INC),  8'h00, 0, 8'hFF, 1, 0));
    vecs.push_back(mk("inc_wrap",   0, 0, 1, 3'(MODE_INC),  8'h00, 0, 8'h00, 1, 1));
    vecs.push_back(mk("dec_wrap",   0, 0, 1, 3'(MODE_DEC),  8'h00, 0, 8'hFF, 1, 1));
    vecs.push_back(mk("load_3c",    0, 0, 1, 3'(MODE_LOAD), 8'h3C, 0, 8'h3C, 1, 1));
    vecs.push_back(mk("en0_inc_1",  0, 0, 0, 3'(MODE_INC),  8'h00, 0, 8'h3C, 1, 1));
    vecs.push_back(mk("en0_inc_2",  0, 0, 0, 3'(MODE_INC),  8'h00, 0, 8'h3C, 1, 1));
    vecs.push_back(mk("en0_inc_3",  0, 0, 0, 3'(MODE_INC),  8'h00, 0, 8'h3C, 1, 1));
    vecs.push_back(mk("r_and_s",    1, 1, 1, 3'(MODE_LOAD), 8'h77, 1, 8'h00, 0, 0));
    vecs.push_back(mk("load_fe_b",  0, 0, 1, 3'(MODE_LOAD), 8'hFE, 0, 8'hFE, 0, 0));
    vecs.push_back(mk("inc_mid",    0, 0, 1, 3'(MODE_INC),  8'h00, 0, 8'hFF, 0, 0));
    vecs.push_back(mk("abort_rst",  1, 0, 1, 3'(MODE_INC),  8'h00, 0, 8'h00, 0, 0));
    vecs.push_back(mk("resume_inc", 0, 0, 1, 3'(MODE_INC),  8'h00, 0, 8'h01, 0, 0));
    vecs.push_back(mk("load_80",    0, 0, 1, 3'(MODE_LOAD), 8'h80, 0, 8'h80, 0, 0));
    vecs.push_back(mk("shl_out",    0, 0, 1, 3'(MODE_SHL),  8'h00, 0, 8'h00, 1, 0));
    vecs.push_back(mk("set_clr_so", 0, 1, 0, 3'(MODE_HOLD), 8'h00, 0, 8'hFF, 0, 0));
    vecs.push_back(mk("hold",       0, 0, 1, 3'(MODE_HOLD), 8'h12, 1, 8'hFF, 0, 0));

    foreach (vecs[i]) begin
      drive8(vecs[i].r, vecs[i].s, vecs[i].en, vecs[i].mode, vecs[i].d, vecs[i].si);
      tick();
      chk({vecs[i].name, ".q"},  q8,  vecs[i].q);
      chk({vecs[i].name, ".so"}, so8, vecs[i].so);
      chk({vecs[i].name, ".co"}, co8, vecs[i].co);
      chk({vecs[i].name, ".z"},  z8,  (vecs[i].q == 8'h00) ? 1 : 0);
    end

    drive4(1, 0, 0, 3'(MODE_HOLD), 4'h0, 0); tick();
    chk("w4_reset.q", q4, 4'h9); chk("w4_reset.co", co4, 0); chk("w4_reset.z", z4, 0);
    drive4(0, 0, 1, 3'(MODE_LOAD), 4'hE, 0); tick();
    chk("w4_load.q", q4, 4'hE);
    drive4(0, 0, 1, 3'(MODE_INC), 4'h0, 0); tick();
    chk("w4_inc1.q", q4, 4'hF); chk("w4_inc1.co", co4, 0);
    tick();
    chk("w4_inc2.q", q4, 4'h0); chk("w4_inc2.co", co4, 1); chk("w4_inc2.z", z4, 1);
    drive4(0, 0, 1, 3'(MODE_DEC), 4'h0, 0); tick();
    chk("w4_dec.q", q4, 4'hF); chk("w4_dec.co", co4, 1);

    drive8(1, 0, 0, 3'(MODE_HOLD), 8'h00, 0);
    drive4(1, 0, 0, 3'(MODE_HOLD), 4'h0, 0);
    tick();
    q8m = 0; so8m = 0; co8m = 0;
    q4m = 9; so4m = 0; co4m = 0;
    for (int n = 0; n < 400; n++) begin
      bit rr, ss, ee, ii;
      int mm, dd;
      rr = ($urandom_range(0, 19) == 0); ss = ($urandom_range(0, 19) == 0);
      ee = ($urandom_range(0, 3) != 0);  ii = 1'($urandom);
      mm = $urandom_range(0, 7);         dd = $urandom_range(0, 255);
      drive8(rr, ss, ee, 3'(mm), 8'(dd), ii);
      model(8, 0, rr, ss, ee, mm, dd, ii, q8m, so8m, co8m);
      rr = ($urandom_range(0, 19) == 0); ss = ($urandom_range(0, 19) == 0);
      ee = ($urandom_range(0, 3) != 0);  ii = 1'($urandom);
      mm = $urandom_range(0, 7);         dd = $urandom_range(0, 15);
      drive4(rr, ss, ee, 3'(mm), 4'(dd), ii);
      model(4, 9, rr, ss, ee, mm, dd, ii, q4m, so4m, co4m);
      tick();
      chk("rnd8.q", q8, q8m);   chk("rnd8.so", so8, so8m);
      chk("rnd8.co", co8, co8m); chk("rnd8.z", z8, (q8m == 0) ? 1 : 0);
      chk("rnd4.q", q4, q4m);   chk("rnd4.so", so4, so4m);
      chk("rnd4.co", co4, co4m); chk("rnd4.z", z4, (q4m == 0) ? 1 : 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/universal_register.md
UNIVERSAL_REGISTER -- requirements
Module: universal_register

Interface
REQ-001 SHALL provide parameter WIDTH, default 8, register width in bits (legal range 2..32).
REQ-002 SHALL provide parameter RESET_VAL, default 0, WIDTH-bit value loaded by reset.
REQ-003 SHALL provide port CLK  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL provide port R  input  1  reset, synchronous, active-high.
REQ-005 SHALL provide port S  input  1  synchronous set; all Q bits to 1.
REQ-006 SHALL provide port MODE  input  3  operation select (encodings per REQ-012).
REQ-007 SHALL provide port EN  input  1  operation enable; when low, MODE is ignored and Q holds.
REQ-008 SHALL provide port D  input  WIDTH  parallel load data.
REQ-009 SHALL provide port SI  input  1  serial input bit for shift modes.
REQ-010 SHALL provide port Q  output  WIDTH  registered contents.
REQ-011 SHALL provide ports SO (output, 1, bit shifted out on last shift/rotate), CO (output, 1, registered carry/borrow), Z (output, 1, high when Q == 0, combinational from Q).

Function
REQ-012 MODE encodings SHALL be: 000 HOLD, 001 LOAD, 010 SHL, 011 SHR, 100 ROTL, 101 ROTR, 110 INC, 111 DEC.
REQ-013 Priority per edge SHALL be R > S > (EN & MODE) > hold.
REQ-014 LOAD: Q <= D; one-cycle latency, D visible on Q after the edge.
REQ-015 SHL: Q <= {Q[WIDTH-2:0], SI}; SO <= old Q[WIDTH-1].
REQ-016 SHR: Q <= {SI, Q[WIDTH-1:1]}; SO <= old Q[0].
REQ-017 ROTL: Q <= {Q[WIDTH-2:0], Q[WIDTH-1]}; SO <= old Q[WIDTH-1]; SI ignored.
REQ-018 ROTR: Q <= {Q[0], Q[WIDTH-1:1]}; SO <= old Q[0]; SI ignored.
REQ-019 INC: Q <= Q + 1 modulo 2^WIDTH; CO <= 1 only when old Q is all ones (wrap to 0), else 0.
REQ-020 DEC: Q <= Q - 1 modulo 2^WIDTH; CO <= 1 only when old Q == 0 (wrap to all ones), else 0.
REQ-021 SO SHALL update only on shift/rotate operations and hold otherwise.
REQ-022 CO SHALL update only on INC/DEC operations and hold otherwise.
REQ-023 S asserted (R low) SHALL force Q to all ones, clear CO and SO, regardless of EN/MODE.
REQ-024 HOLD or EN low SHALL leave Q, SO, CO unchanged.
REQ-025 Z SHALL track Q with no added latency.

Reset
REQ-026 R high at a rising edge SHALL set Q <= RESET_VAL, SO <= 0, CO <= 0, overriding S, EN, MODE.
REQ-027 R asserted mid-sequence (e.g. during repeated INC or shifting) SHALL abort it; next edge with R low resumes from RESET_VAL with no retained history.
REQ-028 No asynchronous path from R to any output other than through Z following Q.

Structure
REQ-029 MODE encodings and named mode constants SHALL live in shared package ureg_pkg, used by RTL and bench.
REQ-030 Per-bit next-state selection and storage SHALL be one sub-module, ureg_bit_cell (next-value mux plus D flip-flop), instantiated WIDTH times via generate; INC/DEC adder, SO, CO, Z logic in the top level.
REQ-031 Design SHALL be fully synchronous, single clock domain, no latches.

Verification
REQ-032 WIDTH=8: R=1 one edge -> Q=0x00, SO=0, CO=0, Z=1; then S=1 -> Q=0xFF, Z=0.
REQ-033 LOAD D=0xA5, then SHL SI=1 -> Q=0x4B, SO=1; then SHR SI=0 -> Q=0x25, SO=1.
REQ-034 LOAD 0x81, ROTL -> Q=0x03, SO=1; ROTR -> Q=0x81, SO=1.
REQ-035 LOAD 0xFE, INC x2 -> Q=0xFF CO=0, then Q=0x00 CO=1 Z=1; DEC -> Q=0xFF CO=1.
REQ-036 LOAD 0x3C, EN=0 with MODE=INC for 3 edges -> Q=0x3C, CO unchanged; R and S both high -> Q=RESET_VAL.
REQ-037 Repeat REQ-035 with WIDTH=4, RESET_VAL=4'h9: reset -> Q=0x9; from 0xE INC x2 -> 0xF, 0x0 with CO=1.
